alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu.sv | 160 ++++++++++++++++
 tb/tb_alu_mdu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Combinational ALU plus multi-cycle multiply/divide unit with HI/LO registers.
// Build option: define ALU_MDU_SIGNED_EN to make mdOp 00/10 two's-complement signed.
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [3:0]       ALUctrl,
  input  logic             start,
  input  logic [1:0]       mdOp,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] result,
  output logic             ALUzero,
  output logic             ifgtz,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             latch_ops, wr_md, wr_hi, wr_lo;

  // ---------------- combinational ALU ----------------
  logic [SHW-1:0] shamt;
  assign shamt = dataA[SHW-1:0];

  always_comb begin
    // NOTE: default first so every path assigns result -- no latch for codes 10-15.
    result = '0;
    case (ALUctrl)
      4'd0: result = dataA & dataB;
      4'd1: result = dataA | dataB;
      4'd2: result = dataA + dataB;
      4'd3: result = dataA - dataB;
      4'd4: result = dataA ^ dataB;
      4'd5: result = dataB << shamt;
      4'd6: result = dataB >> shamt;
      4'd7: result = $unsigned($signed(dataB) >>> shamt);
      4'd8: result = {{(WIDTH-1){1'b0}}, $signed(dataA) < $signed(dataB)};
      4'd9: result = {{(WIDTH-1){1'b0}}, dataA < dataB};
      default: result = '0;
    endcase
  end

  assign ALUzero = (result == '0);
  assign ifgtz   = ~dataA[WIDTH-1] & (|dataA);

  // ---------------- multiply / divide datapath ----------------
  logic signed_op;
`ifdef ALU_MDU_SIGNED_EN
  assign signed_op = ~op_q[0];
`else
  logic unused_op;
  assign signed_op = 1'b0;
  assign unused_op = op_q[0];
`endif

  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  assign a_ext   = {{WIDTH{signed_op & a_q[WIDTH-1]}}, a_q};
  assign b_ext   = {{WIDTH{signed_op & b_q[WIDTH-1]}}, b_q};
  assign product = a_ext * b_ext;

  // Divide on magnitudes, then restore signs; MIN/-1 falls out as MIN rem 0.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign a_neg = signed_op & a_q[WIDTH-1];
  assign b_neg = signed_op & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign q_mag = a_mag / ((b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag);
  assign r_mag = a_mag % ((b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag);

  always_comb begin
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
    if (b_q == '0) begin
      quot = '1;
      rem  = a_q;
    end else if (signed_op && a_q == MIN_VAL && b_q == '1) begin
      quot = MIN_VAL;
      rem  = '0;
    end
  end

  // ---------------- control FSM ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_ops = 1'b0;
    wr_md     = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_ops = 1'b1;
          state_d   = mdOp[1] ? DIV : MUL;
          cnt_d     = mdOp[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end else begin
          wr_hi = mthi;
          wr_lo = mtlo;
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          wr_md   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == MUL) || (state_q == DIV);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi      <= '0;
      lo      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_ops) begin
        a_q  <= dataA;
        b_q  <= dataB;
        op_q <= mdOp;
      end
      if (wr_md) begin
        hi <= (state_q == MUL) ? product[2*WIDTH-1:WIDTH] : rem;
        lo <= (state_q == MUL) ? product[WIDTH-1:0]       : quot;
      end else begin
        if (wr_hi) hi <= dataA;
        if (wr_lo) lo <= dataA;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed ALU vectors and a scoreboard for MDU results.
module tb_alu_mdu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  dataA, dataB;
  logic [3:0]    ALUctrl;
  logic          start, mthi, mtlo;
  logic [1:0]    mdOp;
  logic [W-1:0]  result, hi, lo;
  logic          ALUzero, ifgtz, busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cycles;
  } md_exp_t;

  md_exp_t sb[$];

  alu_mdu dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .ALUctrl(ALUctrl),
    .start(start), .mdOp(mdOp), .mthi(mthi), .mtlo(mtlo), .result(result),
    .ALUzero(ALUzero), .ifgtz(ifgtz), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_model(input logic [3:0] c, input logic [W-1:0] a, b);
    int sh;
    logic [63:0] ext;
    sh = int'(a % 32);
    case (c)
      0: return a & b;
      1: return a | b;
      2: return W'(64'(a) + 64'(b));
      3: return W'(64'(a) + 64'(~b) + 64'd1);
      4: return a ^ b;
      5: return W'(64'(b) << sh);
      6: return W'(64'(b) >> sh);
      7: begin
        ext = {{32{b[31]}}, b};
        return W'(ext >> sh);
      end
      8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9: return (longint'({32'b0, a}) < longint'({32'b0, b})) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  function automatic md_exp_t md_model(input logic [1:0] op, input logic [W-1:0] a, b);
    md_exp_t e;
    bit sgn;
    longint p;
`ifdef ALU_MDU_SIGNED_EN
    sgn = !op[0];
`else
    sgn = 1'b0;
`endif
    e.cycles = op[1] ? 10 : 5;
    if (!op[1]) begin
      p = sgn ? longint'(int'(a)) * longint'(int'(b))
              : longint'({32'b0, a}) * longint'({32'b0, b});
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'h0;
    end else if (sgn) begin
      e.lo = 32'(int'(a) / int'(b));
      e.hi = 32'(int'(a) % int'(b));
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  task automatic alu_vec(input logic [3:0] c, input logic [W-1:0] a, b);
    logic [W-1:0] exp;
    ALUctrl = c; dataA = a; dataB = b;
    #1;
    exp = alu_model(c, a, b);
    check($sformatf("alu%0d_result", c), result, exp);
    check($sformatf("alu%0d_zero", c), W'(ALUzero), W'(exp == 0));
    check($sformatf("alu%0d_gtz", c), W'(ifgtz), W'(int'(a) > 0));
  endtask

  // Launch an op, optionally disturb inputs mid-flight, then compare against the scoreboard.
  task automatic md_run(input logic [1:0] op, input logic [W-1:0] a, b, input bit disturb);
    md_exp_t e;
    int cyc;
    @(negedge clk);
    dataA = a; dataB = b; mdOp = op; start = 1'b1;
    sb.push_back(md_model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (disturb && cyc == 2) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        dataA = 32'hDEAD_BEEF; dataB = 32'h3; mdOp = ~op;
      end
      if (disturb && cyc == 4) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    check($sformatf("md%0d_busy_cycles", op), W'(cyc), W'(e.cycles));
    check($sformatf("md%0d_hi", op), hi, e.hi);
    check($sformatf("md%0d_lo", op), lo, e.lo);
  endtask

  initial begin
    reset = 1'b1; dataA = '0; dataB = '0; ALUctrl = '0;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mdOp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;

    // ALU vectors
    alu_vec(4'd3, 32'd5, 32'd5);
    alu_vec(4'd0, 32'h8000_0000, 32'hF0F0_1234);
    alu_vec(4'd1, 32'h0000_00FF, 32'h1200_0000);
    alu_vec(4'd2, 32'hFFFF_FFFF, 32'd1);
    alu_vec(4'd3, 32'd0, 32'd1);
    alu_vec(4'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    alu_vec(4'd5, 32'd36, 32'h0000_0001);
    alu_vec(4'd6, 32'd31, 32'h8000_0000);
    alu_vec(4'd7, 32'd4, 32'h8000_0010);
    alu_vec(4'd8, 32'hFFFF_FFFF, 32'd1);
    alu_vec(4'd9, 32'hFFFF_FFFF, 32'd1);
    alu_vec(4'd12, 32'h7, 32'h9);
    alu_vec(4'd15, 32'h1, 32'h1);

    // MDU operations
    md_run(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    md_run(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    md_run(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    md_run(2'b11, 32'd9, 32'd0, 1'b1);
    md_run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    md_run(2'b11, 32'd100, 32'd7, 1'b0);
    md_run(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // start has priority over mthi/mtlo in the same cycle
    @(negedge clk);
    dataA = 32'd6; dataB = 32'd7; mdOp = 2'b01; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("prio_hi_unchanged", hi, md_model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0).hi);
    check("prio_busy", W'(busy), 32'd1);

    // reset during busy cycle 3 aborts with no write
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", W'(busy), '0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_late_write", lo, '0);

    // mthi / mtlo writes
    @(negedge clk);
    dataA = 32'h1234; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, '0);
    @(negedge clk);
    dataA = 32'hCAFE_0001; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", hi, 32'hCAFE_0001);
    check("mthilo_lo", lo, 32'hCAFE_0001);

    check("sb_empty", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
